// File: rtl/hack_ctrl.sv
// hack_ctrl: Hack CPU control FSM driving an external ALU, ROM and RAM; define HACK_CTRL_HALT_EN to halt on a jump-to-self
module hack_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rom_req,
  output logic [14:0] rom_addr,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  output logic        ram_rd,
  output logic        ram_wr,
  output logic [14:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic        ram_ack,
  input  logic [15:0] ram_rdata,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        zx,
  output logic        nx,
  output logic        zy,
  output logic        ny,
  output logic        f,
  output logic        no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [14:0] pc,
  output logic        halted
);
  typedef enum logic [2:0] {
    FETCH, DECODE, MEMRD, EXEC, MEMWR
`ifdef HACK_CTRL_HALT_EN
    , HALT
`endif
  } state_t;
  state_t state, nxt;
  logic [15:0] a, d, m, ir, wd;
  logic [14:0] wa;
  logic jmp;
  assign jmp = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_zr & ~alu_ng);
`ifdef HACK_CTRL_HALT_EN
  logic hit;
  assign hit = &ir[2:0] && a[14:0] == pc;
  assign halted = state == HALT;
`else
  assign halted = 1'b0;
`endif
  assign rom_req = rst_n && state == FETCH;
  assign ram_rd = state == MEMRD;
  assign ram_wr = state == MEMWR;
  assign rom_addr = pc;
  assign ram_addr = state == MEMWR ? wa : a[14:0];
  assign ram_wdata = wd;
  assign alu_x = d;
  assign alu_y = ir[12] ? m : a;
  assign {zx, nx, zy, ny, f, no} = ir[11:6];
  always_comb begin
    nxt = state;
    case (state)
      FETCH:  nxt = rom_ack ? DECODE : FETCH;
      DECODE: nxt = !ir[15] ? FETCH : ir[12] ? MEMRD : EXEC;
      MEMRD:  nxt = ram_ack ? EXEC : MEMRD;
`ifdef HACK_CTRL_HALT_EN
      EXEC:   nxt = hit ? HALT : ir[3] ? MEMWR : FETCH;
`else
      EXEC:   nxt = ir[3] ? MEMWR : FETCH;
`endif
      MEMWR:  nxt = ram_ack ? FETCH : MEMWR;
      default: nxt = state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      pc <= '0;
      a <= '0;
      d <= '0;
      m <= '0;
      ir <= '0;
      wa <= '0;
      wd <= '0;
    end else begin
      state <= nxt;
      if (state == FETCH && rom_ack) ir <= rom_data;
      if (state == DECODE && !ir[15]) begin
        a <= ir;
        pc <= pc + 15'd1;
      end
      if (state == MEMRD && ram_ack) m <= ram_rdata;
      if (state == EXEC) begin
        if (ir[4]) d <= alu_out;
        if (ir[5]) a <= alu_out;
        pc <= jmp ? a[14:0] : pc + 15'd1;
        wa <= a[14:0];
        wd <= alu_out;
      end
    end
endmodule

// File: tb/tb_hack_ctrl.sv
// tb_hack_ctrl: randomized ISA-level reference model bench for hack_ctrl
module tb_hack_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rom_req, rom_ack = 1'b0, ram_rd, ram_wr, ram_ack = 1'b0;
  logic [14:0] rom_addr, ram_addr, pc;
  logic [15:0] rom_data = '0, ram_wdata, ram_rdata = '0, alu_x, alu_y, alu_out;
  logic zx, nx, zy, ny, f, no, alu_zr, alu_ng, halted;
  hack_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .alu_x(alu_x), .alu_y(alu_y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .pc(pc), .halted(halted)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] r;
    x = c[5] ? 16'h0 : x;
    x = c[4] ? ~x : x;
    y = c[3] ? 16'h0 : y;
    y = c[2] ? ~y : y;
    r = c[1] ? x + y : x & y;
    return c[0] ? ~r : r;
  endfunction
  assign alu_out = alu(alu_x, alu_y, {zx, nx, zy, ny, f, no});
  assign alu_zr = alu_out == 16'h0;
  assign alu_ng = alu_out[15];
  int checks = 0, errors = 0;
  int rom_w, ram_w;
  logic [14:0] mpc;
  logic [15:0] ma, md;
  logic [15:0] ram [0:32767];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int wt(input int w);
    return w < 0 ? int'($urandom_range(0, 2)) : w;
  endfunction
  function automatic logic [15:0] rand_ins();
    if ($urandom_range(0, 2) == 0) return {1'b0, 15'($urandom_range(0, 31))};
    return {1'b1, 15'($urandom)};
  endfunction
  task automatic do_reset();
    rst_n = 1'b0;
    rom_ack = 1'b0;
    ram_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_strobes", {rom_req, ram_rd, ram_wr, halted}, 0);
    chk("rst_pc", {rom_addr, pc}, 0);
    chk("rst_a", ram_addr, 0);
    chk("rst_d", alu_x, 0);
    chk("rst_y", alu_y, 0);
    chk("rst_ctrl", {zx, nx, zy, ny, f, no}, 0);
    rst_n = 1'b1;
    mpc = '0;
    ma = '0;
    md = '0;
  endtask
  task automatic step(input logic [15:0] ins);
    int n, er, ew, nr, nw, cyc;
    logic [15:0] a0, d0, y, out, rv;
    logic jmp, hlt;
    n = 0;
    while (!rom_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req", rom_req, 1);
    chk("pc", {rom_addr, pc}, {mpc, mpc});
    chk("d_reg", alu_x, md);
    chk("a_reg", ram_addr, ma[14:0]);
    chk("fetch_excl", {ram_rd, ram_wr, halted}, 0);
    repeat (wt(rom_w)) begin
      rom_ack = 1'b0;
      @(negedge clk);
      chk("rom_hold", {rom_req, rom_addr}, {1'b1, mpc});
    end
    rom_data = ins;
    rom_ack = 1'b1;
    @(negedge clk);
    rom_ack = 1'b0;
    rom_data = 16'($urandom);
    a0 = ma;
    d0 = md;
    er = 0;
    ew = 0;
    hlt = 1'b0;
    out = '0;
    if (!ins[15]) begin
      ma = ins;
      mpc = mpc + 15'd1;
    end else begin
      y = ins[12] ? ram[a0[14:0]] : a0;
      out = alu(d0, y, ins[11:6]);
      jmp = (ins[2] && out[15]) || (ins[1] && out == 0) || (ins[0] && out != 0 && !out[15]);
`ifdef HACK_CTRL_HALT_EN
      hlt = ins[2:0] == 3'b111 && a0[14:0] == mpc;
`endif
      er = ins[12] ? 1 : 0;
      ew = ins[3] && !hlt ? 1 : 0;
      if (ins[4]) md = out;
      if (ins[5]) ma = out;
      mpc = jmp ? a0[14:0] : mpc + 15'd1;
    end
    chk("alu_ctrl", {zx, nx, zy, ny, f, no}, ins[11:6]);
    if (ins[15] && !ins[12]) chk("alu_y_a", alu_y, a0);
    nr = 0;
    nw = 0;
    cyc = 0;
    while (!rom_req && !halted && cyc < 60) begin
      if (ram_rd) begin
        nr++;
        chk("rd_addr", {rom_req, ram_wr, ram_addr}, {2'b00, a0[14:0]});
        repeat (wt(ram_w)) begin
          ram_ack = 1'b0;
          @(negedge clk);
          chk("rd_hold", {ram_rd, ram_addr}, {1'b1, a0[14:0]});
        end
        rv = ram[a0[14:0]];
        ram_rdata = rv;
        ram_ack = 1'b1;
        @(negedge clk);
        ram_ack = 1'b0;
        ram_rdata = 16'($urandom);
        chk("alu_y_m", alu_y, rv);
      end else if (ram_wr) begin
        nw++;
        chk("wr_addr", {rom_req, ram_rd, ram_addr}, {2'b00, a0[14:0]});
        chk("wr_data", ram_wdata, out);
        repeat (wt(ram_w)) begin
          ram_ack = 1'b0;
          @(negedge clk);
          chk("wr_hold", {ram_wr, ram_addr, ram_wdata}, {1'b1, a0[14:0], out});
        end
        ram[a0[14:0]] = out;
        ram_ack = 1'b1;
        @(negedge clk);
        ram_ack = 1'b0;
      end else begin
        rom_ack = 1'($urandom);
        ram_ack = 1'($urandom);
        rom_data = 16'($urandom);
        @(negedge clk);
        rom_ack = 1'b0;
        ram_ack = 1'b0;
        cyc++;
      end
    end
    chk("nreads", nr, er);
    chk("nwrites", nw, ew);
    chk("halted", halted, hlt);
    if (!ins[15]) chk("a_instr_cycles", cyc, 1);
    if (hlt) begin
      repeat (5) @(negedge clk);
      chk("halt_quiet", {rom_req, ram_rd, ram_wr, halted}, 4'b0001);
      do_reset();
    end
  endtask
  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 16'($urandom);
    ram[100] = 16'd5;
    rom_w = 0;
    ram_w = 0;
    do_reset();
    step(16'h0005);
    step(16'h0007);
    step(16'hEC10);
    step(16'hE7D0);
    step(16'h0003);
    step(16'hECD0);
    step(16'd100);
    step(16'hF090);
    step(16'h0009);
    step(16'hEC10);
    step(16'd200);
    ram_w = 3;
    step(16'hE308);
    ram_w = 0;
    step(16'd12);
    step(16'hEA90);
    step(16'hE302);
    step(16'd12);
    step(16'hEFD0);
    step(16'hE302);
    step(16'h7FFF);
    step(16'hEA87);
    step(16'h0001);
`ifdef HACK_CTRL_HALT_EN
    step({1'b0, 15'(mpc + 15'd1)});
    step(16'hEA87);
`endif
    rom_w = -1;
    ram_w = -1;
    repeat (300) step(rand_ins());
    step(16'd100);
    rom_data = 16'hFC10;
    rom_ack = 1'b1;
    @(negedge clk);
    rom_ack = 1'b0;
    @(negedge clk);
    chk("memrd_pending", {ram_rd, ram_addr}, {1'b1, 15'd100});
    #2 rst_n = 1'b0;
    #1 chk("rst_drops_rd", {rom_req, ram_rd, ram_wr}, 0);
    @(negedge clk);
    chk("rst_held_quiet", {rom_req, ram_rd, ram_wr}, 0);
    rst_n = 1'b1;
    mpc = '0;
    ma = '0;
    md = '0;
    #1 chk("refetch_0", {rom_req, rom_addr}, {1'b1, 15'd0});
    @(negedge clk);
    step(16'h0002);
    step(16'hEC10);
    step(16'h0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hack_ctrl.md
HACK_CTRL -- requirements
Module: hack_ctrl

Interface
REQ-001 One clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 rom_req / rom_addr / rom_ack / rom_data  out 1 / out 15 / in 1 / in 16  instruction fetch port.
REQ-005 ram_rd / ram_wr / ram_addr / ram_wdata  out 1 / out 1 / out 15 / out 16  data memory request.
REQ-006 ram_ack / ram_rdata  in 1 / in 16  data memory completion and read data.
REQ-007 alu_x / alu_y  out 16  ALU operands: x = D register; y = M (when IR[12]=1) or A.
REQ-008 zx, nx, zy, ny, f, no  out 1 each  ALU control, taken from IR[11:6] in that order.
REQ-009 alu_out / alu_zr / alu_ng  in 16 / in 1 / in 1  ALU result and flags from the external alu.
REQ-010 pc  out 15  current program counter.
REQ-011 halted  out 1  halt indication (see Configuration).

Function
REQ-012 States: FETCH, DECODE, MEMRD, EXEC, MEMWR, HALT; encoding is free.
REQ-013 FETCH: rom_req=1, rom_addr=pc, held stable until rom_ack is sampled high; IR<=rom_data; go to DECODE.
REQ-014 DECODE, IR[15]=0 (A-instruction): A<=IR, pc<=pc+1, go to FETCH; total 2 cycles with zero-wait ack.
REQ-015 DECODE, IR[15]=1 and IR[12]=1: go to MEMRD; IR[12]=0: go to EXEC.
REQ-016 MEMRD: ram_rd=1, ram_addr=A[14:0] until ram_ack; M<=ram_rdata; go to EXEC.
REQ-017 EXEC samples alu_out/alu_zr/alu_ng combinationally in its single cycle: IR[4] loads D, IR[5] loads A, IR[3] requests an M write.
REQ-018 Jump taken = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~zr&~ng); taken: pc<=A (value before this instruction's A update); else pc<=pc+1.
REQ-019 EXEC next state: MEMWR when IR[3]=1, else FETCH.
REQ-020 MEMWR: ram_wr=1, ram_addr = A before the EXEC update, ram_wdata = alu_out latched in EXEC, held until ram_ack; then FETCH.
REQ-021 Strobes (rom_req, ram_rd, ram_wr) are mutually exclusive; never more than one high.
REQ-022 Acks sampled while the matching strobe is low are ignored.
REQ-023 pc increments modulo 2^15; 32767 wraps to 0.
REQ-024 ALU outputs are driven continuously from registers; their values are only consumed in EXEC.
REQ-025 IR[14:13] of a C-instruction are ignored.

Reset
REQ-026 rst_n low: state=FETCH; pc, A, D, M, IR = 0; rom_req, ram_rd, ram_wr, halted = 0, all asynchronously.
REQ-027 Reset mid-transaction drops the strobe immediately; the aborted access is never retried; first fetch after release is address 0.

Configuration
REQ-028 Macro HACK_CTRL_HALT_EN defined: in EXEC, an unconditional jump (IR[2:0]=111) whose target A equals the current pc enters HALT; halted=1; no further strobes until reset.
REQ-029 HACK_CTRL_HALT_EN undefined: no HALT state; such a jump loops normally; halted is tied 0.

Verification
REQ-030 ROM[0]=0x0005 (@5), zero-wait acks -> A=5, pc=1 after 2 cycles; no ram strobe.
REQ-031 @7; D=A (0xEC10); D=D+1 (0xE7D0) -> D=8; zx..no = 011111 seen in the EXEC of D+1.
REQ-032 A=100, D=-3, ram[100]=5; D=D+M (0xF090) -> ram_rd at addr 100 before EXEC; D=2.
REQ-033 A=200, D=9; M=D (0xE308) -> single ram_wr, addr 200, data 9, held across 3 wait cycles until ram_ack.
REQ-034 A=12, D=0; D;JEQ (0xE302) -> pc=12; D=1 with the same instruction -> pc=old pc+1; with HALT_EN, @k at k-1 followed by 0;JMP at k -> halted=1, no further rom_req.
REQ-035 Assert rst_n low during a MEMRD wait -> ram_rd low the same instant; after release, rom_req at rom_addr 0.
